// File: rtl/seven_seg_digit_driver.sv
// Seven-segment digit driver: follows the scanner's active-low anode ring and emits the
// selected digit's segments, with frame-aligned commit of new display values.
module seven_seg_digit_driver #(
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter logic [15:0] RESET_VALUE    = 16'h0000
) (
    input  logic        div_clock,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        blank_lz,
    input  logic        load,
    output logic        pending,
    output logic        committed,
    output logic [3:0]  anode_out,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        err
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

    // Active-low hex font, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            4'hF:    code = 7'h0E;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    logic [15:0] display_r;
    logic [3:0]  dp_reg_r;
    logic [15:0] pend_buf_r;
    logic [3:0]  pend_dp_r;
    logic        pending_r;
    logic        committed_r;
    logic [3:0]  anode_out_r;
    logic [6:0]  seg_r;
    logic        dp_n_r;
    logic        err_r;

    logic        boundary_s;
    logic        legal_s;
    logic [1:0]  digit_idx_s;
    logic [3:0]  nibble_s;
    logic        blank_s;
    logic [6:0]  seg_raw_s;
    logic [6:0]  seg_next_s;
    logic        dp_n_next_s;

    // Anode decode, digit selection, leading-zero blanking and polarity
    always_comb begin
        boundary_s  = (anode == 4'b0111);
        legal_s     = 1'b0;
        digit_idx_s = 2'd0;
        nibble_s    = 4'h0;
        blank_s     = 1'b0;
        seg_raw_s   = 7'h7F;
        seg_next_s  = SEG_OFF;
        dp_n_next_s = DP_OFF;

        case (anode)
            4'b1110: begin legal_s = 1'b1; digit_idx_s = 2'd0; end
            4'b1101: begin legal_s = 1'b1; digit_idx_s = 2'd1; end
            4'b1011: begin legal_s = 1'b1; digit_idx_s = 2'd2; end
            4'b0111: begin legal_s = 1'b1; digit_idx_s = 2'd3; end
            default: begin legal_s = 1'b0; digit_idx_s = 2'd0; end
        endcase

        // A digit is a leading zero when it and every higher nibble are zero
        case (digit_idx_s)
            2'd0:    begin nibble_s = display_r[3:0];   blank_s = 1'b0; end
            2'd1:    begin nibble_s = display_r[7:4];   blank_s = (display_r[15:4] == 12'h000); end
            2'd2:    begin nibble_s = display_r[11:8];  blank_s = (display_r[15:8] == 8'h00); end
            2'd3:    begin nibble_s = display_r[15:12]; blank_s = (display_r[15:12] == 4'h0); end
            default: begin nibble_s = 4'h0;             blank_s = 1'b0; end
        endcase

        if (blank_lz && blank_s) begin
            seg_raw_s = 7'h7F;
        end else begin
            seg_raw_s = hex_to_seg(nibble_s);
        end

        if (legal_s) begin
            seg_next_s  = SEG_ACTIVE_LOW ? seg_raw_s : ~seg_raw_s;
            dp_n_next_s = SEG_ACTIVE_LOW ? ~dp_reg_r[digit_idx_s] : dp_reg_r[digit_idx_s];
        end else begin
            seg_next_s  = SEG_OFF;
            dp_n_next_s = DP_OFF;
        end
    end

    // Pending buffer and frame-boundary commit into the display register
    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            display_r   <= RESET_VALUE;
            dp_reg_r    <= 4'h0;
            pend_buf_r  <= 16'h0000;
            pend_dp_r   <= 4'h0;
            pending_r   <= 1'b0;
            committed_r <= 1'b0;
        end else if (boundary_s && pending_r) begin
            display_r   <= pend_buf_r;
            dp_reg_r    <= pend_dp_r;
            committed_r <= 1'b1;
            if (load) begin
                pend_buf_r <= value;
                pend_dp_r  <= dp;
                pending_r  <= 1'b1;
            end else begin
                pending_r  <= 1'b0;
            end
        end else if (load) begin
            pend_buf_r  <= value;
            pend_dp_r   <= dp;
            pending_r   <= 1'b1;
            committed_r <= 1'b0;
        end else begin
            committed_r <= 1'b0;
        end
    end

    // Output pad registers: anode and segments move on the same edge
    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            anode_out_r <= 4'hF;
            seg_r       <= SEG_OFF;
            dp_n_r      <= DP_OFF;
        end else if (legal_s) begin
            anode_out_r <= anode;
            seg_r       <= seg_next_s;
            dp_n_r      <= dp_n_next_s;
        end else begin
            anode_out_r <= 4'hF;
            seg_r       <= SEG_OFF;
            dp_n_r      <= DP_OFF;
        end
    end

    // Sticky illegal-anode flag
    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (!legal_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign pending   = pending_r;
    assign committed = committed_r;
    assign anode_out = anode_out_r;
    assign seg       = seg_r;
    assign dp_n      = dp_n_r;
    assign err       = err_r;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Bench for seven_seg_digit_driver: per-cycle comparison against a behavioural model,
// plus literal expectations for the directed scenarios.
module tb_seven_seg_digit_driver;

    logic        div_clock = 1'b0;
    logic        reset     = 1'b0;
    logic [3:0]  anode     = 4'b1110;
    logic [15:0] value     = 16'h0000;
    logic [3:0]  dp        = 4'h0;
    logic        blank_lz  = 1'b0;
    logic        load      = 1'b0;
    logic        pending;
    logic        committed;
    logic [3:0]  anode_out;
    logic [6:0]  seg;
    logic        dp_n;
    logic        err;

    int tests = 0;
    int fails = 0;

    seven_seg_digit_driver dut (
        .div_clock (div_clock),
        .reset     (reset),
        .anode     (anode),
        .value     (value),
        .dp        (dp),
        .blank_lz  (blank_lz),
        .load      (load),
        .pending   (pending),
        .committed (committed),
        .anode_out (anode_out),
        .seg       (seg),
        .dp_n      (dp_n),
        .err       (err)
    );

    always #5 div_clock = ~div_clock;

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: {dp_n, seg} for a given display value, dp bits, anode and blanking mode
    function automatic logic [7:0] model_out(input logic [15:0] disp, input logic [3:0] dpv,
                                             input logic [3:0] an, input logic blz);
        int idx = 0;
        int zeros = 0;
        logic [15:0] upper;
        logic [6:0] s;
        for (int i = 0; i < 4; i++) begin
            if (an[i] == 1'b0) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros != 1) return {1'b1, 7'h7F};
        upper = disp >> (4 * idx);
        if (blz && idx > 0 && upper == 16'h0000) s = 7'h7F;
        else s = FONT[upper[3:0]];
        return {~dpv[idx], s};
    endfunction

    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pend_dp;
    logic        m_pending;
    logic [3:0]  exp_anode_out;
    logic [7:0]  exp_out;
    logic        exp_err, exp_committed;

    // Behavioural model of the buffer and display pipeline
    always @(posedge div_clock or posedge reset) begin
        if (reset) begin
            m_disp <= 16'h0000; m_dp <= 4'h0; m_pend <= 16'h0000; m_pend_dp <= 4'h0;
            m_pending <= 1'b0; exp_committed <= 1'b0; exp_anode_out <= 4'hF;
            exp_out <= {1'b1, 7'h7F}; exp_err <= 1'b0;
        end else begin
            exp_out <= model_out(m_disp, m_dp, anode, blank_lz);
            exp_anode_out <= ($countones(~anode) == 1) ? anode : 4'hF;
            exp_err <= exp_err || ($countones(~anode) != 1);
            exp_committed <= (anode == 4'b0111) && m_pending;
            if (anode == 4'b0111 && m_pending) begin
                m_disp <= m_pend;
                m_dp   <= m_pend_dp;
            end
            if (load) begin
                m_pend <= value;
                m_pend_dp <= dp;
                m_pending <= 1'b1;
            end else if (anode == 4'b0111) begin
                m_pending <= 1'b0;
            end
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge div_clock) begin
        check("model_anode_out", {12'h000, anode_out}, {12'h000, exp_anode_out});
        check("model_seg", {9'h000, seg}, {9'h000, exp_out[6:0]});
        check("model_dp_n", {15'h0000, dp_n}, {15'h0000, exp_out[7]});
        check("model_err", {15'h0000, err}, {15'h0000, exp_err});
        check("model_pending", {15'h0000, pending}, {15'h0000, m_pending});
        check("model_committed", {15'h0000, committed}, {15'h0000, exp_committed});
    end

    task automatic step(input logic [3:0] a, input logic ld, input logic [15:0] v, input logic [3:0] d);
        anode = a; load = ld; value = v; dp = d;
        @(posedge div_clock);
        #1;
        load = 1'b0;
    endtask

    task automatic idle(input logic [3:0] a);
        step(a, 1'b0, 16'h0000, 4'h0);
    endtask

    initial begin
        // 1: reset state, then first decoded digit
        #1 reset = 1'b1;
        #2;
        check("rst_anode_out", {12'h000, anode_out}, 16'h000F);
        check("rst_seg", {9'h000, seg}, 16'h007F);
        check("rst_dp_n", {15'h0000, dp_n}, 16'h0001);
        check("rst_pending", {15'h0000, pending}, 16'h0000);
        check("rst_err", {15'h0000, err}, 16'h0000);
        @(negedge div_clock);
        @(negedge div_clock);
        reset = 1'b0;
        idle(4'b1110);
        check("t1_anode_out", {12'h000, anode_out}, 16'h000E);
        check("t1_seg", {9'h000, seg}, 16'h0040);

        // 2: load 1234 mid-frame, commit at boundary, show next frame
        step(4'b1101, 1'b1, 16'h1234, 4'b0001);
        check("t2_pending", {15'h0000, pending}, 16'h0001);
        idle(4'b1011);
        idle(4'b0111);
        check("t2_committed", {15'h0000, committed}, 16'h0001);
        check("t2_pending_clr", {15'h0000, pending}, 16'h0000);
        idle(4'b1110);
        check("t2_d0", {9'h000, seg}, 16'h0019);
        check("t2_d0_dp", {15'h0000, dp_n}, 16'h0000);
        check("t2_committed_clr", {15'h0000, committed}, 16'h0000);
        idle(4'b1101);
        check("t2_d1", {9'h000, seg}, 16'h0030);
        idle(4'b1011);
        check("t2_d2", {9'h000, seg}, 16'h0024);
        idle(4'b0111);
        check("t2_d3", {9'h000, seg}, 16'h0079);

        // 3: leading-zero blanking, blanked digit keeps its dp
        blank_lz = 1'b1;
        step(4'b1110, 1'b1, 16'h0008, 4'b0100);
        idle(4'b1101); idle(4'b1011); idle(4'b0111);
        idle(4'b1110);
        check("t3_d0", {9'h000, seg}, 16'h0000);
        idle(4'b1101);
        check("t3_d1_blank", {9'h000, seg}, 16'h007F);
        idle(4'b1011);
        check("t3_d2_blank", {9'h000, seg}, 16'h007F);
        check("t3_d2_dp", {15'h0000, dp_n}, 16'h0000);
        idle(4'b0111);
        check("t3_d3_blank", {9'h000, seg}, 16'h007F);
        blank_lz = 1'b0;
        idle(4'b1110); idle(4'b1101); idle(4'b1011);
        check("t3_d2_zero", {9'h000, seg}, 16'h0040);
        idle(4'b0111);
        check("t3_d3_zero", {9'h000, seg}, 16'h0040);

        // 4: two loads within one frame, no torn frame
        step(4'b1110, 1'b1, 16'hAAAA, 4'h0);
        idle(4'b1101); idle(4'b1011); idle(4'b0111);
        idle(4'b1110);
        check("t4_old_d0", {9'h000, seg}, 16'h0008);
        step(4'b1101, 1'b1, 16'h5555, 4'h0);
        check("t4_old_d1", {9'h000, seg}, 16'h0008);
        step(4'b1011, 1'b1, 16'hFFFF, 4'h0);
        check("t4_old_d2", {9'h000, seg}, 16'h0008);
        idle(4'b0111);
        check("t4_old_d3", {9'h000, seg}, 16'h0008);
        idle(4'b1110);
        check("t4_new_d0", {9'h000, seg}, 16'h000E);
        idle(4'b1101); idle(4'b1011); idle(4'b0111);
        check("t4_new_d3", {9'h000, seg}, 16'h000E);

        // 5: load on a committing boundary stays pending for the next frame
        step(4'b1110, 1'b1, 16'h3333, 4'h0);
        idle(4'b1101); idle(4'b1011);
        step(4'b0111, 1'b1, 16'h2222, 4'h0);
        check("t5_committed", {15'h0000, committed}, 16'h0001);
        check("t5_pending", {15'h0000, pending}, 16'h0001);
        idle(4'b1110);
        check("t5_first_d0", {9'h000, seg}, 16'h0030);
        idle(4'b1101); idle(4'b1011); idle(4'b0111);
        check("t5_second_commit", {15'h0000, committed}, 16'h0001);
        idle(4'b1110);
        check("t5_second_d0", {9'h000, seg}, 16'h0024);

        // 6: illegal anodes, sticky err, asynchronous mid-frame reset
        idle(4'b1100);
        check("t6_anode_out", {12'h000, anode_out}, 16'h000F);
        check("t6_seg", {9'h000, seg}, 16'h007F);
        check("t6_err", {15'h0000, err}, 16'h0001);
        idle(4'b1111);
        check("t6_err_f", {15'h0000, err}, 16'h0001);
        idle(4'b1110);
        check("t6_err_sticky", {15'h0000, err}, 16'h0001);
        check("t6_recover_seg", {9'h000, seg}, 16'h0024);
        step(4'b1101, 1'b1, 16'h9999, 4'hF);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_anode_out", {12'h000, anode_out}, 16'h000F);
        check("t6_rst_seg", {9'h000, seg}, 16'h007F);
        check("t6_rst_err", {15'h0000, err}, 16'h0000);
        check("t6_rst_pending", {15'h0000, pending}, 16'h0000);
        @(negedge div_clock);
        reset = 1'b0;
        idle(4'b1110); idle(4'b1101); idle(4'b1011); idle(4'b0111);
        check("t6_no_commit", {15'h0000, committed}, 16'h0000);
        idle(4'b1110);
        check("t6_discarded", {9'h000, seg}, 16'h0040);
        @(negedge div_clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
